mlp_patch_seq: RTL and testbench
================================

MLP_PATCH_SEQ -- requirements
Module: mlp_patch_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- P, 2, pixels per beat
- W_X, 4, magnitude width
- W_Y, 17, MLP score magnitude width (score is W_Y+1 bits, signed)
- N_BEATS, 25, beats per patch
- W_A, 5, patch memory address width
- TIMEOUT, 255, maximum cycles to wait for a result
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-low
- start, in, 1, request to classify the stored patch
- thr, in, W_Y+1, signed decision threshold
- mem_rd, out, 1, patch memory read strobe
- mem_addr, out, W_A, patch memory word address
- mem_rdata, in, P*(W_X+2), {pol[P-1],mag[P-1],...,pol[0],mag[0]}, valid 1 cycle after mem_rd
- mlp_in_vld, out, 1, beat valid to the MLP
- mlp_in_mag, out, P*W_X, beat magnitudes
- mlp_in_pol, out, P*2, beat polarities
- mlp_out, in, W_Y+1, MLP score
- mlp_out_vld, in, 1, MLP score valid; may stay high several cycles
- busy, out, 1, high outside IDLE
- done, out, 1, one-cycle completion pulse
- score, out, W_Y+1, latched score
- is_signal, out, 1, score >= thr (signed)
- err_timeout, out, 1, result missing

Function
REQ-003 The FSM SHALL have states IDLE, FEED, WAIT, DONE, HOLD.
REQ-004 IDLE SHALL go to FEED on start=1. In all other states, start SHALL be ignored.
REQ-005 FEED SHALL assert mem_rd for exactly N_BEATS consecutive cycles, with mem_addr = 0,1,...,N_BEATS-1. FEED SHALL then go to WAIT.
REQ-006 mem_rdata SHALL be registered into mlp_in_mag/mlp_in_pol. mlp_in_vld SHALL be mem_rd delayed 2 cycles, giving N_BEATS contiguous valid beats and no gaps.
REQ-007 When mlp_in_vld=0, mlp_in_mag and mlp_in_pol SHALL be 0.
REQ-008 In WAIT, the first cycle with mlp_out_vld=1 SHALL latch score<=mlp_out and is_signal<=($signed(mlp_out) >= $signed(thr)), then go to DONE.
REQ-009 WAIT SHALL be entered only after the last beat has left. mlp_out_vld outside WAIT SHALL be ignored.
REQ-010 DONE SHALL last exactly 1 cycle with done=1, then go to HOLD.
REQ-011 HOLD SHALL go to IDLE in the first cycle with mlp_out_vld=0. If mlp_out_vld is already 0, this takes 1 cycle.
REQ-012 score, is_signal and err_timeout SHALL hold their values until the next DONE.
REQ-013 busy SHALL be 1 in FEED, WAIT, DONE and HOLD. busy SHALL be 0 in IDLE.
REQ-014 start asserted in the same cycle the FSM enters IDLE SHALL be accepted on the next edge.

Reset
REQ-015 On rst=0, asynchronously: FSM SHALL be IDLE, and mem_rd, mem_addr, mlp_in_vld, mlp_in_mag, mlp_in_pol, busy, done, score, is_signal, err_timeout and all counters SHALL be 0.
REQ-016 Reset during FEED or WAIT SHALL abort the patch with no done pulse. Operation SHALL resume from IDLE after rst returns to 1.

Configuration
REQ-017 With macro MLP_SEQ_TIMEOUT_EN defined:
- A WAIT cycle counter SHALL run.
- If TIMEOUT cycles elapse in WAIT without mlp_out_vld, the block SHALL go to DONE with err_timeout=1, score=0, is_signal=0.
- err_timeout SHALL clear on the next successful DONE.
REQ-018 Without MLP_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely and err_timeout SHALL be tied 0.

Verification
REQ-019 Nominal run: start pulse, memory model with 1-cycle latency, MLP model returning score 100 with thr=50.
- mem_addr SHALL be 0..24 on consecutive cycles.
- mlp_in_vld SHALL be high for 25 contiguous cycles starting 2 cycles after the first mem_rd, with beats matching memory contents.
- done SHALL be a single pulse, with score=100 and is_signal=1.
REQ-020 Negative score: MLP score -3 with thr=0 -> is_signal=0 and score=18'h3FFFD.
REQ-021 Busy and out_vld handling: start pulsed every cycle while busy -> exactly one patch (25 beats) per done. MLP out_vld held high for 4 cycles -> one done, then IDLE on the cycle after out_vld falls.
REQ-022 Reset mid-run: rst=0 at beat 10 -> all outputs 0 immediately and no done. A new start after reset -> full 25-beat run.
REQ-023 Timeout: with MLP_SEQ_TIMEOUT_EN and the MLP never answering, done SHALL occur TIMEOUT cycles after entering WAIT with err_timeout=1. A following normal run SHALL clear err_timeout.

Source files
------------

// File: rtl/mlp_patch_seq.sv
// mlp_patch_seq: streams a stored patch from memory into an MLP and latches the thresholded score.
// Optional WAIT timeout is enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_patch_seq #(
  parameter int unsigned P       = 2,
  parameter int unsigned W_X     = 4,
  parameter int unsigned W_Y     = 17,
  parameter int unsigned N_BEATS = 25,
  parameter int unsigned W_A     = 5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W_Y:0]           thr,
  output logic                   mem_rd,
  output logic [W_A-1:0]         mem_addr,
  input  logic [P*(W_X+2)-1:0]   mem_rdata,
  output logic                   mlp_in_vld,
  output logic [P*W_X-1:0]       mlp_in_mag,
  output logic [P*2-1:0]         mlp_in_pol,
  input  logic [W_Y:0]           mlp_out,
  input  logic                   mlp_out_vld,
  output logic                   busy,
  output logic                   done,
  output logic [W_Y:0]           score,
  output logic                   is_signal,
  output logic                   err_timeout
);

  localparam int unsigned W_PIX = W_X + 2;
  localparam int unsigned W_T   = $clog2(TIMEOUT + 1);
`ifdef MLP_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FEED, WAIT, DONE, HOLD} state_t;

  state_t             state;
  logic               rd_d1;
  logic [W_T-1:0]     wait_cnt;
  logic [P*W_X-1:0]   mag_c;
  logic [P*2-1:0]     pol_c;
  logic               score_ge_c;

  // Unpack {pol,mag} pixel slots of the memory word into separate buses.
  always_comb begin
    mag_c = '0;
    pol_c = '0;
    for (int unsigned i = 0; i < P; i++) begin
      mag_c[i*W_X +: W_X] = mem_rdata[i*W_PIX +: W_X];
      pol_c[i*2 +: 2]     = mem_rdata[i*W_PIX + W_X +: 2];
    end
  end

  assign score_ge_c = $signed(mlp_out) >= $signed(thr);

  // Beat pipeline: read data arrives one cycle after mem_rd, then is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_d1      <= 1'b0;
      mlp_in_vld <= 1'b0;
      mlp_in_mag <= '0;
      mlp_in_pol <= '0;
    end else begin
      rd_d1      <= mem_rd;
      mlp_in_vld <= rd_d1;
      mlp_in_mag <= rd_d1 ? mag_c : '0;
      mlp_in_pol <= rd_d1 ? pol_c : '0;
    end
  end

  // Sequencer; FEED also drains the beat pipeline before handing over to WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      score       <= '0;
      is_signal   <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FEED;
            mem_rd   <= 1'b1;
            mem_addr <= '0;
            busy     <= 1'b1;
          end
        end
        FEED: begin
          if (mem_rd) begin
            if (mem_addr == W_A'(N_BEATS - 1)) begin
              mem_rd   <= 1'b0;
              mem_addr <= '0;
            end else begin
              mem_addr <= mem_addr + W_A'(1);
            end
          end else if (!rd_d1) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (mlp_out_vld) begin
            score       <= mlp_out;
            is_signal   <= score_ge_c;
            err_timeout <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (TO_EN && (wait_cnt == W_T'(TIMEOUT - 1))) begin
            score       <= '0;
            is_signal   <= 1'b0;
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt + W_T'(1);
          end
        end
        DONE: state <= HOLD;
        HOLD: begin
          if (!mlp_out_vld) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_patch_seq.sv
// Self-checking bench for mlp_patch_seq: random patches and scores against a cycle-level reference.
module tb_mlp_patch_seq;

  localparam int unsigned P       = 2;
  localparam int unsigned W_X     = 4;
  localparam int unsigned W_Y     = 17;
  localparam int unsigned N_BEATS = 25;
  localparam int unsigned W_A     = 5;
  localparam int unsigned TIMEOUT = 40;
  localparam int unsigned W_D     = P*(W_X+2);
`ifdef MLP_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [W_Y:0]       thr;
  logic               mem_rd;
  logic [W_A-1:0]     mem_addr;
  logic [W_D-1:0]     mem_rdata;
  logic               mlp_in_vld;
  logic [P*W_X-1:0]   mlp_in_mag;
  logic [P*2-1:0]     mlp_in_pol;
  logic [W_Y:0]       mlp_out;
  logic               mlp_out_vld;
  logic               busy;
  logic               done;
  logic [W_Y:0]       score;
  logic               is_signal;
  logic               err_timeout;

  mlp_patch_seq #(
    .P(P), .W_X(W_X), .W_Y(W_Y), .N_BEATS(N_BEATS), .W_A(W_A), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .thr(thr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mlp_in_vld(mlp_in_vld), .mlp_in_mag(mlp_in_mag), .mlp_in_pol(mlp_in_pol),
    .mlp_out(mlp_out), .mlp_out_vld(mlp_out_vld),
    .busy(busy), .done(done), .score(score), .is_signal(is_signal),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [W_D-1:0] mem [N_BEATS];

  int             addr_q[$];
  int             rd_cyc[$];
  logic [W_D-1:0] beat_q[$];
  int             vld_cyc[$];
  int             done_q[$];
  int             zero_viol;

  always @(posedge clk) cyc <= cyc + 1;

  // Patch memory with one cycle read latency; garbage when not reading.
  always @(posedge clk)
    mem_rdata <= (mem_rd && (int'(mem_addr) < int'(N_BEATS))) ? mem[mem_addr] : W_D'($urandom);

  // Observation log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rd) begin
      addr_q.push_back(int'(mem_addr));
      rd_cyc.push_back(cyc);
    end
    if (mlp_in_vld) begin
      beat_q.push_back({mlp_in_pol, mlp_in_mag});
      vld_cyc.push_back(cyc);
    end else if (mlp_in_mag != '0 || mlp_in_pol != '0) begin
      zero_viol++;
    end
    if (done) done_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat: memory word {pol1,mag1,pol0,mag0} regrouped as {pol1,pol0,mag1,mag0}.
  function automatic logic [W_D-1:0] beat_of(input logic [W_D-1:0] w);
    return {w[11:10], w[5:4], w[9:6], w[3:0]};
  endfunction

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({mem_rd, mem_addr, mlp_in_vld, mlp_in_mag, mlp_in_pol,
                busy, done, score, is_signal, err_timeout});
  endfunction

  task automatic clear_logs();
    addr_q.delete(); rd_cyc.delete(); beat_q.delete(); vld_cyc.delete(); done_q.delete();
    zero_viol = 0;
  endtask

  task automatic run_patch(input string tag, input logic [W_Y:0] sc, input logic [W_Y:0] th,
                           input int hold_len, input bit start_all, input bit no_answer);
    int a, w, st_cyc, idle_cyc, n, bad, exp_idle;
    bit seen, to_flag;
    logic [W_Y:0] exp_sc;
    logic exp_sig, exp_err;
    for (int i = 0; i < int'(N_BEATS); i++) mem[i] = W_D'($urandom);
    to_flag = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) to_flag = 1'b1;
    clear_logs();
    start = 1'b1; thr = th; st_cyc = cyc;
    seen = 1'b0; n = 0;
    // Feed phase with spurious MLP results that must be ignored.
    forever begin
      @(negedge clk); n++;
      if (!start_all) start = 1'b0;
      if (mlp_in_vld) seen = 1'b1;
      if ((seen && !mlp_in_vld) || n >= 100) break;
      mlp_out_vld = 1'($urandom); mlp_out = (W_Y+1)'($urandom);
    end
    if (n >= 100) to_flag = 1'b1;
    w = cyc;
    mlp_out_vld = 1'b0;
    exp_sc  = sc;
    exp_sig = (int'($signed(sc)) >= int'($signed(th)));
    exp_err = 1'b0;
    if (!no_answer || !TO_EN) begin
      if (no_answer) begin
        repeat (3*TIMEOUT) @(negedge clk);
        chk({tag, ":stall_busy"}, 64'(busy), 64'(1));
        chk({tag, ":stall_done"}, 64'(done_q.size()), 64'(0));
      end
      a = cyc; mlp_out_vld = 1'b1; mlp_out = sc;
      repeat (hold_len) @(negedge clk);
      mlp_out_vld = 1'b0; mlp_out = (W_Y+1)'($urandom);
    end else begin
      a = w + int'(TIMEOUT) - 1;
      exp_sc = '0; exp_sig = 1'b0; exp_err = 1'b1; hold_len = 1;
    end
    start = 1'b0;
    exp_idle = (hold_len < 2) ? a + 3 : a + hold_len + 1;
    n = 0;
    while (busy && n < int'(TIMEOUT) + 50) begin @(negedge clk); n++; end
    if (busy) to_flag = 1'b1;
    idle_cyc = cyc;

    chk({tag, ":bound"}, 64'(to_flag), 64'(0));
    chk({tag, ":n_rd"}, 64'(addr_q.size()), 64'(N_BEATS));
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != i) bad++;
    chk({tag, ":addr_seq"}, 64'(bad), 64'(0));
    chk({tag, ":rd_first"}, 64'(first_of(rd_cyc)), 64'(st_cyc + 1));
    chk({tag, ":rd_span"}, 64'(last_of(rd_cyc) - first_of(rd_cyc)), 64'(N_BEATS - 1));
    chk({tag, ":n_beat"}, 64'(beat_q.size()), 64'(N_BEATS));
    bad = 0;
    foreach (beat_q[i]) if (i >= int'(N_BEATS) || beat_q[i] !== beat_of(mem[i])) bad++;
    chk({tag, ":beats"}, 64'(bad), 64'(0));
    chk({tag, ":vld_lat"}, 64'(first_of(vld_cyc)), 64'(first_of(rd_cyc) + 2));
    chk({tag, ":vld_span"}, 64'(last_of(vld_cyc) - first_of(vld_cyc)), 64'(N_BEATS - 1));
    chk({tag, ":idle_zero"}, 64'(zero_viol), 64'(0));
    chk({tag, ":n_done"}, 64'(done_q.size()), 64'(1));
    chk({tag, ":done_cyc"}, 64'(first_of(done_q)), 64'(a + 1));
    chk({tag, ":idle_cyc"}, 64'(idle_cyc), 64'(exp_idle));
    chk({tag, ":score"}, 64'(score), 64'(exp_sc));
    chk({tag, ":is_signal"}, 64'(is_signal), 64'(exp_sig));
    chk({tag, ":err_timeout"}, 64'(err_timeout), 64'(exp_err));
  endtask

  initial begin
    logic [W_Y:0] v;
    int k;
    rst = 1'b0; start = 1'b0; thr = '0; mlp_out = '0; mlp_out_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:outs", outs_vec(), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("reset:idle", outs_vec(), 64'(0));

    run_patch("nominal",  (W_Y+1)'(100), (W_Y+1)'(50), 1, 1'b0, 1'b0);
    run_patch("negative", 18'h3FFFD, '0, 1, 1'b0, 1'b0);
    chk("negative:score_hex", 64'(score), 64'h3FFFD);
    run_patch("busy_hold4", (W_Y+1)'($urandom), (W_Y+1)'($urandom), 4, 1'b1, 1'b0);
    v = (W_Y+1)'($urandom);
    run_patch("equal", v, v, 2, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      run_patch($sformatf("rand%0d", r), (W_Y+1)'($urandom), (W_Y+1)'($urandom),
                int'($urandom_range(1, 3)), 1'($urandom), 1'b0);
    run_patch("no_answer", (W_Y+1)'($urandom), (W_Y+1)'($urandom), 1, 1'b0, 1'b1);
    run_patch("after_wait", (W_Y+1)'($urandom), (W_Y+1)'($urandom), 1, 1'b0, 1'b0);

    // Reset at beat 10 aborts the patch without a done pulse.
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 10 && rd_cyc.size() < 60) begin
      if (mlp_in_vld) k++;
      if (k < 10) @(negedge clk);
    end
    chk("midreset:beats_seen", 64'(k), 64'(10));
    rst = 1'b0;
    #1;
    chk("midreset:outs", outs_vec(), 64'(0));
    repeat (5) @(negedge clk);
    chk("midreset:held", outs_vec(), 64'(0));
    chk("midreset:no_done", 64'(done_q.size()), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    run_patch("post_reset", (W_Y+1)'($urandom), (W_Y+1)'($urandom), 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
